audio_pwm_out: RTL
==================

Name: audio_pwm_out

Overview:
- Audio output path: the processor pushes 16-bit signed PCM samples (MMIO store strobe) into a small FIFO.
- The FIFO is drained at the audio sample rate, derived from the 40 MHz system clock.
- Each sample is rendered as a pulse-width-modulated bit on the board's mono audio jack.
- Sits beside the processor in the top-level wrapper, the opposite direction of the analog audio input path.

Parameters:
- SAMPLE_DIV, 909, system clocks per audio sample (40 MHz / 909 ≈ 44.0 kHz).
- PWM_W, 8, PWM resolution in bits; carrier period 2^PWM_W clocks.
- ADDR_W, 4, FIFO address width; depth = 2^ADDR_W.

Ports:
- clock  in  1  system clock (40 MHz).
- reset  in  1  synchronous, active-high reset.
- wEn  in  1  processor write strobe; pushes dataIn[15:0] when asserted.
- dataIn  in  32  bits [15:0] = signed two's-complement sample; [31:16] ignored.
- enable  in  1  playback enable.
- clear_flags  in  1  clears sticky overflow/underrun.
- full  out  1  FIFO full.
- level  out  ADDR_W+1  FIFO occupancy.
- overflow  out  1  sticky: a write was dropped.
- underrun  out  1  sticky: a sample tick found the FIFO empty.
- sample_tick  out  1  one-cycle pulse at each sample boundary.
- AUD_PWM  out  1  PWM audio output.
- AUD_SD  out  1  amplifier enable; equals registered enable.

Behaviour:
- Reset (synchronous, active-high), all outputs registered:
  - FIFO empty, level=0, full=0.
  - div_cnt=0, pwm_cnt=0.
  - cur_sample=16'h8000 (offset-binary midscale), duty=2^(PWM_W-1).
  - overflow=0, underrun=0, sample_tick=0, AUD_PWM=0, AUD_SD=0.
  - Reset asserted mid-playback discards all queued samples.
- Write:
  - wEn with full=0 enqueues dataIn[15:0]; level increments the next cycle.
  - wEn with full=1 and no pop in the same cycle: write dropped, overflow set.
  - wEn with full=1 and a pop in the same cycle: write accepted, level unchanged.
  - Writes are accepted regardless of enable.
- Sample divider:
  - When enable=1, div_cnt counts 0..SAMPLE_DIV-1 and wraps.
  - sample_tick=1 in the cycle after div_cnt==SAMPLE_DIV-1.
  - When enable=0, div_cnt is held at 0.
- On each tick:
  - FIFO non-empty: pop; cur_sample <= popped ^ 16'h8000 (signed to offset binary).
  - FIFO empty: cur_sample <= 16'h8000 and underrun set.
- PWM:
  - When enable=1, pwm_cnt free-runs over PWM_W bits.
  - duty <= cur_sample[15 -: PWM_W] only when pwm_cnt == all-ones, so a carrier period is never truncated.
  - AUD_PWM <= (pwm_cnt < duty). duty=0 gives constant 0; the maximum duty gives high for 2^PWM_W-1 of 2^PWM_W clocks.
- enable=0:
  - pwm_cnt held at 0, AUD_PWM=0, AUD_SD=0.
  - cur_sample and duty retain their values; FIFO contents retained.
  - Re-enable restarts both counters from 0.
- Flags: clear_flags clears overflow and underrun. If a setting event occurs in the same cycle, the set wins.
- Simultaneous wEn and pop on an empty FIFO: the tick sees empty, so underrun is set and midscale is loaded. The write is accepted, level=1.
- Latency, write to audible:
  - Write lands in the FIFO on the next edge.
  - Consumed at the next tick.
  - Visible on AUD_PWM at the next carrier wrap plus 1 clock.

Decomposition:
- Package audio_pkg:
  - SAMPLE_W=16.
  - MIDSCALE=16'h8000.
  - Default SAMPLE_DIV/PWM_W/ADDR_W constants.
  - Function to_offset_binary.
- Sub-module sync_fifo (parameterised width/ADDR_W):
  - push/pop/full/empty/level.
  - Simultaneous push+pop when full is legal.
- audio_pwm_out holds the divider, sample register, PWM generator and flags.

Test Plan:
- Reset: assert reset 2 cycles while enable=1 with 3 samples queued -> level=0, AUD_PWM=0, AUD_SD=0, duty=0x80, flags 0.
- Sample conversion (SAMPLE_DIV=8, PWM_W=8): write 16'h7FFF, 16'h8000, 16'h0000 -> duty sequence 0xFF, 0x00, 0x80. AUD_PWM high 255/256, 0/256 and 128/256 clocks per carrier period respectively.
- Tick timing: enable at cycle 0 -> sample_tick pulses exactly at cycles 8, 16, 24 (SAMPLE_DIV=8), each one cycle wide.
- Overflow: 17 writes to depth-16 FIFO with enable=0 -> full=1 after write 16, level=16, overflow=1. The 17th value is never played. clear_flags -> overflow=0.
- Underrun: enable with empty FIFO -> underrun=1 at first tick, duty stays 0x80. A write plus clear_flags in the same cycle as a tick -> underrun remains 1.
- Full boundary: FIFO full, wEn coincident with tick -> no overflow, level stays 16, written sample played last.

Source files
------------

// File: rtl/audio_pwm_out_pkg.sv
// Shared constants and sample-format helper for the audio PWM output path.
// Samples arrive as signed two's complement and are played as offset binary.
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam logic [SAMPLE_W-1:0] MIDSCALE = 16'h8000;
  localparam int SAMPLE_DIV_DEF = 909;
  localparam int PWM_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;

  function automatic logic [SAMPLE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] s);
    return s ^ MIDSCALE;
  endfunction
endpackage

// File: rtl/audio_pwm_out_if.sv
// Processor-side MMIO bus and board-side audio pins of the PWM output path.
// Writes are never stalled; a write to a full FIFO with no pop is dropped and flagged.
interface audio_pwm_out_if #(
  parameter int ADDR_W = audio_pkg::ADDR_W_DEF
) ();
  logic              wEn;
  logic [31:0]       dataIn;
  logic              enable;
  logic              clear_flags;
  logic              full;
  logic [ADDR_W:0]   level;
  logic              overflow;
  logic              underrun;
  logic              sample_tick;
  logic              AUD_PWM;
  logic              AUD_SD;

  modport master (
    output wEn, dataIn, enable, clear_flags,
    input  full, level, overflow, underrun, sample_tick, AUD_PWM, AUD_SD
  );

  modport slave (
    input  wEn, dataIn, enable, clear_flags,
    output full, level, overflow, underrun, sample_tick, AUD_PWM, AUD_SD
  );
endinterface

// File: rtl/audio_pwm_out_sync_fifo.sv
// Single-clock FIFO with registered level/full/empty; push lands on the next edge.
// Caller must not push when full unless popping in the same cycle, and must not pop when empty.
module sync_fifo #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_push,
  input  logic [WIDTH-1:0]  i_din,
  input  logic              i_pop,
  output logic [WIDTH-1:0]  o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              r_full;
  logic              r_empty;
  logic [ADDR_W:0]   w_level_nxt;

  always_comb begin
    w_level_nxt = r_level;
    case ({i_push, i_pop})
      2'b10:   w_level_nxt = r_level + 1'b1;
      2'b01:   w_level_nxt = r_level - 1'b1;
      default: w_level_nxt = r_level;
    endcase
  end

  always_ff @(posedge clock) begin
    if (i_push) r_mem[r_wr_ptr] <= i_din;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == (ADDR_W+1)'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = r_full;
  assign o_empty = r_empty;
  assign o_level = r_level;
endmodule

// File: rtl/audio_pwm_out.sv
// Sample-rate FIFO drain into a PWM carrier; write-to-audible is next tick, then next carrier wrap + 1 clock.
// No backpressure to the processor: overflow/underrun are reported through sticky flags.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int SAMPLE_DIV = SAMPLE_DIV_DEF,
  parameter int PWM_W      = PWM_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF
) (
  input  logic        clock,
  input  logic        reset,
  audio_pwm_out_if.slave bus
);
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [DIV_W-1:0]    r_div_cnt;
  logic [PWM_W-1:0]    r_pwm_cnt;
  logic [PWM_W-1:0]    r_duty;
  logic [SAMPLE_W-1:0] r_cur_sample;
  logic                r_sample_tick;
  logic                r_overflow;
  logic                r_underrun;
  logic                r_pwm;
  logic                r_sd;

  logic [SAMPLE_W-1:0] w_fifo_dout;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic [ADDR_W:0]     w_fifo_level;
  logic                w_tick;
  logic                w_pop;
  logic                w_push;
  logic                w_unused_hi;

  // A tick consumes only while playing, so a pause never skips a queued sample.
  assign w_tick      = r_sample_tick & bus.enable;
  assign w_pop       = w_tick & ~w_fifo_empty;
  assign w_push      = bus.wEn & (~w_fifo_full | w_pop);
  assign w_unused_hi = ^bus.dataIn[31:16];

  sync_fifo #(
    .WIDTH  (SAMPLE_W),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (w_push),
    .i_din   (bus.dataIn[SAMPLE_W-1:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_level (w_fifo_level)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_div_cnt     <= '0;
      r_pwm_cnt     <= '0;
      r_duty        <= PWM_W'(1 << (PWM_W-1));
      r_cur_sample  <= MIDSCALE;
      r_sample_tick <= 1'b0;
      r_overflow    <= 1'b0;
      r_underrun    <= 1'b0;
      r_pwm         <= 1'b0;
      r_sd          <= 1'b0;
    end else begin
      r_sample_tick <= 1'b0;
      if (bus.enable) begin
        if (r_div_cnt == DIV_W'(SAMPLE_DIV-1)) begin
          r_div_cnt     <= '0;
          r_sample_tick <= 1'b1;
        end else begin
          r_div_cnt <= r_div_cnt + 1'b1;
        end
      end else begin
        r_div_cnt <= '0;
      end

      if (w_tick) r_cur_sample <= w_pop ? to_offset_binary(w_fifo_dout) : MIDSCALE;

      r_pwm_cnt <= bus.enable ? r_pwm_cnt + 1'b1 : '0;
      // Duty only changes at the carrier wrap so a period is never cut short.
      if (bus.enable && (&r_pwm_cnt)) r_duty <= r_cur_sample[SAMPLE_W-1 -: PWM_W];
      r_pwm <= bus.enable && (r_pwm_cnt < r_duty);
      r_sd  <= bus.enable;

      if (bus.wEn && w_fifo_full && !w_pop) r_overflow <= 1'b1;
      else if (bus.clear_flags)             r_overflow <= 1'b0;

      if (w_tick && w_fifo_empty)  r_underrun <= 1'b1;
      else if (bus.clear_flags)    r_underrun <= 1'b0;
    end
  end

  assign bus.full        = w_fifo_full;
  assign bus.level       = w_fifo_level;
  assign bus.overflow    = r_overflow;
  assign bus.underrun    = r_underrun;
  assign bus.sample_tick = r_sample_tick;
  assign bus.AUD_PWM     = r_pwm;
  assign bus.AUD_SD      = r_sd;
endmodule
